flag_stack_reg: RTL and testbench
=================================

// Module: flag_stack_reg
// PURPOSE
//  Parametrised CPU status-flag register with per-bit write mask, optional sticky bits
//  and a hardware save/restore LIFO. Flags are saved on CALL/interrupt entry and
//  restored on RET. Sits between ALU flag outputs and control unit branch logic.
//  Single-cycle update; all state is in the clk domain.
// PARAMETERS
//  NF          2      number of flag bits (bit0 = Z, bit1 = C by default)
//  DEPTH       4      LIFO entries (>= 1)
//  STICKY_MASK 2'b00  per-bit: 1 = sticky (set-only via write, cleared only by sticky_clr)
//  CNT_W       $clog2(DEPTH+1)  localparam, width of stk_count
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      reset, synchronous, active-high
//  flag_write  in   1      apply flag_in under flag_wmask this cycle
//  flag_wmask  in   NF     per-bit write enable (qualified by flag_write)
//  flag_in     in   NF     new flag values from ALU
//  sticky_clr  in   1      clear all sticky bits
//  push        in   1      save current flag_out onto LIFO
//  pop         in   1      restore flag_out from LIFO top
//  flag_out    out  NF     registered flags
//  stk_count   out  CNT_W  valid LIFO entries, 0..DEPTH
//  stk_full    out  1      stk_count == DEPTH (combinational from count)
//  stk_empty   out  1      stk_count == 0
//  stk_err     out  1      sticky error: overflow/underflow/push+pop collision
// BEHAVIOUR
//  - Reset (rst=1 at edge): flag_out=0, stk_count=0, stk_err=0. LIFO storage not reset
//    (never observable: pop on empty is blocked). rst overrides all other inputs.
//  - Latency: every update visible on flag_out the cycle after the sampling edge.
//  - push_ok = push & ~pop & ~stk_full;  pop_ok = pop & ~push & ~stk_empty.
//  - push_ok: mem[stk_count] <= current flag_out (pre-write value); count+1.
//    Flag write in the same cycle still applies to flag_out.
//  - pop_ok: flag_out <= mem[stk_count-1]; count-1. flag_write and sticky_clr
//    ignored in that cycle (restore has priority).
//  - Otherwise, per bit i:
//      non-sticky: next = (flag_write & wmask[i]) ? flag_in[i] : flag_out[i]
//      sticky:     next = (flag_out[i] & ~sticky_clr) | (flag_write & wmask[i] & flag_in[i])
//    write-set beats sticky_clr on the same bit in the same cycle.
//  - Errors (set stk_err, cleared only by rst; count/mem unchanged for that op):
//      push & stk_full (overflow); pop & stk_empty (underflow); push & pop (collision,
//      both ignored, flag write still applies).
//  - Count never wraps; no state machine beyond the pointer.
// STRUCTURE
//  - flag_pkg: NF/DEPTH defaults, FLAG_Z=0, FLAG_C=1 index constants, STICKY_MASK default.
//  - Sub-module flag_lifo (DEPTH x NF storage, count, full/empty, push/pop guards, err
//    pulses). flag_stack_reg holds flag_out, masking/sticky logic and stk_err.
// TESTING
//  1 rst, then flag_write=1 wmask=11 in=10 -> next cycle flag_out=10; wmask=01 in=01
//    -> flag_out=11; flag_write=0 in=00 -> flag_out holds 11.
//  2 flag_out=01, push; then write 10; pop -> flag_out=01 the cycle after pop,
//    stk_count 1->0, stk_empty=1, stk_err=0.
//  3 DEPTH=4: push 5 times with distinct values -> count=4, stk_full=1, 5th dropped,
//    stk_err=1; 4 pops return values in LIFO order; 5th pop -> flag_out unchanged.
//  4 STICKY_MASK=10: write bit1=1, then write wmask=10 in=00 -> bit1 stays 1;
//    sticky_clr -> bit1=0; sticky_clr with write in=10 same cycle -> bit1=1.
//  5 push & pop same cycle with count=2 -> count stays 2, flag_out updated only by
//    write, stk_err=1; pop with flag_write same cycle -> restored value wins.
//  6 rst asserted mid-sequence with count=3, stk_err=1 -> all outputs 0, stk_empty=1;
//    subsequent pop -> underflow, stk_err=1.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared constants, types and helpers for the status-flag register and its
// save/restore LIFO.
package flag_pkg;

   // Default geometry of the flag register and the save stack.
   localparam int NF_DEF              = 2;
   localparam int DEPTH_DEF           = 4;
   localparam logic [1:0] STICKY_MASK_DEF = 2'b00;

   // Bit positions of the architectural flags in flag_out.
   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;

   // Classification of the stack command presented in a cycle. Only
   // STK_PUSH and STK_POP move data; the three error kinds leave the count
   // and storage untouched.
   typedef enum logic [2:0] {
      STK_IDLE      = 3'd0,
      STK_PUSH      = 3'd1,
      STK_POP       = 3'd2,
      STK_COLLIDE   = 3'd3,
      STK_OVERFLOW  = 3'd4,
      STK_UNDERFLOW = 3'd5
   } stk_op_e;

   // Decode push/pop requests against the current fill level.
   // A simultaneous push and pop is treated as a collision regardless of
   // the fill level, so neither side takes effect.
   function automatic stk_op_e classify_op(input logic push,
                                           input logic pop,
                                           input logic full,
                                           input logic empty);
      stk_op_e op;
      op = STK_IDLE;
      if (push && pop) begin
         op = STK_COLLIDE;
      end else if (push) begin
         op = full ? STK_OVERFLOW : STK_PUSH;
      end else if (pop) begin
         op = empty ? STK_UNDERFLOW : STK_POP;
      end
      return op;
   endfunction

   // True for any command that must latch the sticky stack error.
   function automatic logic is_error_op(input stk_op_e op);
      return (op == STK_COLLIDE) || (op == STK_OVERFLOW) || (op == STK_UNDERFLOW);
   endfunction

endpackage

// File: rtl/flag_lifo.sv
// Save/restore LIFO for the flag register: DEPTH x NF storage plus a fill
// counter. Command semantics: push and pop are single-cycle requests with no
// back-pressure; a request is accepted only when push_ok / pop_ok is high in
// the same cycle, otherwise it is dropped and err_pulse reports why.
// Storage is never reset; an entry is only read after it has been written.
module flag_lifo
   import flag_pkg::*;
#(
   parameter int NF    = NF_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [NF-1:0]    wdata,
   output logic [NF-1:0]    rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             push_ok,
   output logic             pop_ok,
   output logic             err_pulse
);

   // Address width of the storage array (at least one bit).
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CNT_W-1:0] count_q, count_d;
   logic [NF-1:0]    mem_q [DEPTH];
   logic [NF-1:0]    mem_d [DEPTH];
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   stk_op_e          op;

   // Fill-level status comes straight from the counter.
   always_comb begin
      full  = (count_q == CNT_W'(DEPTH));
      empty = (count_q == '0);
      count = count_q;
   end

   // Decode the command and derive the accept/error strobes.
   always_comb begin
      op        = classify_op(push, pop, full, empty);
      push_ok   = (op == STK_PUSH);
      pop_ok    = (op == STK_POP);
      err_pulse = is_error_op(op);
   end

   // Next write slot is the current count; the top entry sits one below.
   always_comb begin
      wr_idx = AW'(count_q);
      rd_idx = AW'(count_q - CNT_W'(1));
      rdata  = mem_q[rd_idx];
   end

   // Counter moves only on an accepted push or pop, so it never wraps.
   always_comb begin
      count_d = count_q;
      if (push_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_ok) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Storage update: accepted push writes the slot at the current count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push_ok) begin
         mem_d[wr_idx] = wdata;
      end
   end

   // Fill counter register; rst empties the stack.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Storage register; contents survive reset because they are unreachable
   // until rewritten.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: rtl/flag_stack_reg.sv
// CPU status-flag register with per-bit write mask, optional sticky bits and
// a hardware save/restore LIFO. Flags are saved on CALL/interrupt entry
// (push) and restored on RET (pop). Every update appears on flag_out one
// cycle after the sampling edge.
module flag_stack_reg
   import flag_pkg::*;
#(
   parameter int            NF          = NF_DEF,
   parameter int            DEPTH       = DEPTH_DEF,
   parameter logic [NF-1:0] STICKY_MASK = NF'(STICKY_MASK_DEF),
   localparam int           CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flag_write,
   input  logic [NF-1:0]    flag_wmask,
   input  logic [NF-1:0]    flag_in,
   input  logic             sticky_clr,
   input  logic             push,
   input  logic             pop,
   output logic [NF-1:0]    flag_out,
   output logic [CNT_W-1:0] stk_count,
   output logic             stk_full,
   output logic             stk_empty,
   output logic             stk_err
);

   logic [NF-1:0] flag_q, flag_d;
   logic          err_q, err_d;

   logic [NF-1:0] lifo_rdata;
   logic          lifo_push_ok;
   logic          lifo_pop_ok;
   logic          lifo_err;
   logic [NF-1:0] wr_en;

   // Save stack: push captures the flags as they are before this cycle's write.
   flag_lifo #(
      .NF    (NF),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_lifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .wdata     (flag_q),
      .rdata     (lifo_rdata),
      .count     (stk_count),
      .full      (stk_full),
      .empty     (stk_empty),
      .push_ok   (lifo_push_ok),
      .pop_ok    (lifo_pop_ok),
      .err_pulse (lifo_err)
   );

   // Per-bit write enable, qualified by the global write strobe.
   always_comb begin
      wr_en = flag_write ? flag_wmask : '0;
   end

   // Next flag value: an accepted restore overrides any write or sticky
   // clear; otherwise sticky bits are set-only with set winning over clear.
   always_comb begin
      flag_d = flag_q;
      if (lifo_pop_ok) begin
         flag_d = lifo_rdata;
      end else begin
         for (int i = 0; i < NF; i++) begin
            if (STICKY_MASK[i]) begin
               flag_d[i] = (flag_q[i] & ~sticky_clr) | (wr_en[i] & flag_in[i]);
            end else begin
               flag_d[i] = wr_en[i] ? flag_in[i] : flag_q[i];
            end
         end
      end
   end

   // Stack error latches any overflow, underflow or collision until reset.
   always_comb begin
      err_d = err_q | lifo_err;
   end

   // Flag and error registers; rst overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_q <= '0;
         err_q  <= 1'b0;
      end else begin
         flag_q <= flag_d;
         err_q  <= err_d;
      end
   end

   // Registered outputs.
   always_comb begin
      flag_out = flag_q;
      stk_err  = err_q;
   end

endmodule

// File: tb/tb_flag_stack_reg.sv
// Table-driven bench for flag_stack_reg (NF=2, DEPTH=4, bit1 sticky).
// Each record holds the inputs for one clock and the hand-computed outputs
// expected after that edge; the expectation is queued when the record is
// driven and popped when the DUT outputs are sampled.
module tb_flag_stack_reg;

   localparam int NF    = 2;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int OW    = NF + CNT_W + 3;

   logic             clk;
   logic             rst;
   logic             flag_write;
   logic [NF-1:0]    flag_wmask;
   logic [NF-1:0]    flag_in;
   logic             sticky_clr;
   logic             push;
   logic             pop;
   logic [NF-1:0]    flag_out;
   logic [CNT_W-1:0] stk_count;
   logic             stk_full;
   logic             stk_empty;
   logic             stk_err;

   typedef struct {
      string            name;
      logic             rst;
      logic             wr;
      logic [NF-1:0]    wm;
      logic [NF-1:0]    fin;
      logic             sclr;
      logic             push;
      logic             pop;
      logic [NF-1:0]    e_flag;
      logic [CNT_W-1:0] e_cnt;
      logic             e_err;
   } vec_t;

   vec_t          vt[$];
   logic [OW-1:0] exp_q[$];
   int            errors;
   int            checks;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   flag_stack_reg #(
      .NF          (NF),
      .DEPTH       (DEPTH),
      .STICKY_MASK (2'b10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flag_write (flag_write),
      .flag_wmask (flag_wmask),
      .flag_in    (flag_in),
      .sticky_clr (sticky_clr),
      .push       (push),
      .pop        (pop),
      .flag_out   (flag_out),
      .stk_count  (stk_count),
      .stk_full   (stk_full),
      .stk_empty  (stk_empty),
      .stk_err    (stk_err)
   );

   // ---------------- table helpers ----------------
   function automatic vec_t mk(input string nm, input logic r, input logic wr,
                               input logic [1:0] wm, input logic [1:0] fin,
                               input logic sclr, input logic ps, input logic pp,
                               input logic [1:0] ef, input int ec, input logic ee);
      vec_t v;
      v.name = nm; v.rst = r; v.wr = wr; v.wm = wm; v.fin = fin;
      v.sclr = sclr; v.push = ps; v.pop = pp;
      v.e_flag = ef; v.e_cnt = CNT_W'(ec); v.e_err = ee;
      return v;
   endfunction

   function automatic logic [OW-1:0] expect_word(input vec_t v);
      return {v.e_flag, v.e_cnt, (v.e_cnt == CNT_W'(DEPTH)), (v.e_cnt == '0), v.e_err};
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input vec_t v);
      @(negedge clk);
      rst        = v.rst;
      flag_write = v.wr;
      flag_wmask = v.wm;
      flag_in    = v.fin;
      sticky_clr = v.sclr;
      push       = v.push;
      pop        = v.pop;
      exp_q.push_back(expect_word(v));
   endtask

   // ---------------- scoreboard ----------------
   task automatic check_step(input string nm);
      logic [OW-1:0] got;
      logic [OW-1:0] exp;
      @(posedge clk);
      #1;
      got = {flag_out, stk_count, stk_full, stk_empty, stk_err};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got flag=%b cnt=%0d full=%b empty=%b err=%b, expected flag=%b cnt=%0d full=%b empty=%b err=%b",
                  nm, got[OW-1 -: NF], got[CNT_W+2:3], got[2], got[1], got[0],
                  exp[OW-1 -: NF], exp[CNT_W+2:3], exp[2], exp[1], exp[0]);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1; flag_write = 1'b0; flag_wmask = '0; flag_in = '0;
      sticky_clr = 1'b0; push = 1'b0; pop = 1'b0;

      //           name            rst wr  wm     fin    sclr push pop  flag   cnt err
      vt.push_back(mk("reset",      1, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0));
      // Basic masked writes.
      vt.push_back(mk("wr_all_10",  0, 1, 2'b11, 2'b10, 0, 0, 0, 2'b10, 0, 0));
      vt.push_back(mk("wr_b0_01",   0, 1, 2'b01, 2'b01, 0, 0, 0, 2'b11, 0, 0));
      vt.push_back(mk("no_wr_hold", 0, 0, 2'b11, 2'b00, 0, 0, 0, 2'b11, 0, 0));
      // Save, overwrite, restore.
      vt.push_back(mk("clr_to_01",  0, 1, 2'b01, 2'b01, 1, 0, 0, 2'b01, 0, 0));
      vt.push_back(mk("push_01",    0, 0, 2'b00, 2'b00, 0, 1, 0, 2'b01, 1, 0));
      vt.push_back(mk("wr_10",      0, 1, 2'b11, 2'b10, 0, 0, 0, 2'b10, 1, 0));
      vt.push_back(mk("pop_01",     0, 0, 2'b00, 2'b00, 0, 0, 1, 2'b01, 0, 0));
      // Fill to DEPTH with distinct saved values (push saves pre-write flags).
      vt.push_back(mk("push_a",     0, 1, 2'b11, 2'b00, 1, 1, 0, 2'b00, 1, 0));
      vt.push_back(mk("push_b",     0, 1, 2'b11, 2'b11, 0, 1, 0, 2'b11, 2, 0));
      vt.push_back(mk("push_c",     0, 1, 2'b11, 2'b10, 1, 1, 0, 2'b10, 3, 0));
      vt.push_back(mk("push_d",     0, 1, 2'b11, 2'b01, 0, 1, 0, 2'b11, 4, 0));
      vt.push_back(mk("push_ovf",   0, 0, 2'b00, 2'b00, 0, 1, 0, 2'b11, 4, 1));
      vt.push_back(mk("pop_d",      0, 0, 2'b00, 2'b00, 0, 0, 1, 2'b10, 3, 1));
      vt.push_back(mk("pop_c",      0, 0, 2'b00, 2'b00, 0, 0, 1, 2'b11, 2, 1));
      vt.push_back(mk("pop_b",      0, 0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 1, 1));
      vt.push_back(mk("pop_a",      0, 0, 2'b00, 2'b00, 0, 0, 1, 2'b01, 0, 1));
      vt.push_back(mk("pop_unf",    0, 0, 2'b00, 2'b00, 0, 0, 1, 2'b01, 0, 1));
      // Sticky bit1.
      vt.push_back(mk("stk_set",    0, 1, 2'b10, 2'b10, 0, 0, 0, 2'b11, 0, 1));
      vt.push_back(mk("stk_keep",   0, 1, 2'b10, 2'b00, 0, 0, 0, 2'b11, 0, 1));
      vt.push_back(mk("stk_clr",    0, 0, 2'b00, 2'b00, 1, 0, 0, 2'b01, 0, 1));
      vt.push_back(mk("stk_set_w",  0, 1, 2'b10, 2'b10, 1, 0, 0, 2'b11, 0, 1));
      vt.push_back(mk("b0_clear",   0, 1, 2'b01, 2'b00, 0, 0, 0, 2'b10, 0, 1));
      // Collision at count 2, then restore beats write.
      vt.push_back(mk("reset2",     1, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0));
      vt.push_back(mk("push_e",     0, 1, 2'b11, 2'b10, 0, 1, 0, 2'b10, 1, 0));
      vt.push_back(mk("push_f",     0, 1, 2'b11, 2'b01, 1, 1, 0, 2'b01, 2, 0));
      vt.push_back(mk("collide",    0, 1, 2'b01, 2'b00, 0, 1, 1, 2'b00, 2, 1));
      vt.push_back(mk("pop_vs_wr",  0, 1, 2'b11, 2'b11, 0, 0, 1, 2'b10, 1, 1));
      // Reset in the middle of a busy stack.
      vt.push_back(mk("push_g",     0, 0, 2'b00, 2'b00, 0, 1, 0, 2'b10, 2, 1));
      vt.push_back(mk("push_h",     0, 0, 2'b00, 2'b00, 0, 1, 0, 2'b10, 3, 1));
      vt.push_back(mk("rst_mid",    1, 1, 2'b11, 2'b11, 0, 1, 0, 2'b00, 0, 0));
      vt.push_back(mk("unf_after",  0, 0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 0, 1));

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i]);
         check_step(vt[i].name);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
